// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared state, forwarding-select and register constants
// Rev 1.0
// ============================================================================
package hazard_pkg;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      MEMWAIT = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd.sv
`default_nettype none
// ============================================================================
// hazard_fwd : forwarding select for one Execute-stage source operand
// Rev 1.0
// ============================================================================
module hazard_fwd
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic       reg_write_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   // Memory stage holds the younger result, so it wins over Writeback.
   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs_e)) begin
         fwd = FWD_M;
      end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs_e)) begin
         fwd = FWD_W;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : forwarding, stall/flush, boot flush, data-memory wait control
// Rev 1.0
// ============================================================================
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int BOOT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           Rs1D,
   input  logic [4:0]           Rs2D,
   input  logic [4:0]           Rs1E,
   input  logic [4:0]           Rs2E,
   input  logic [4:0]           RdE,
   input  logic [4:0]           RdM,
   input  logic [4:0]           RdW,
   input  logic                 ResultSrcE0,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 PCSrcE,
   input  logic                 MemAccessM,
   input  logic                 MemAckM,
   output logic                 MemReqM,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic                 MemErr,
   output logic [CNT_WIDTH-1:0] StallCnt,
   output logic [CNT_WIDTH-1:0] FlushCnt
);

   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int WAIT_W = $clog2(MEM_TIMEOUT);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [BOOT_W-1:0]    boot_q, boot_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 mem_err_q, mem_err_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   logic [1:0] fwd_a, fwd_b;
   logic       lw_stall, mem_timeout, mem_hold, active;

   hazard_fwd u_fwd_a (
      .rs_e(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
      .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_a)
   );

   hazard_fwd u_fwd_b (
      .rs_e(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
      .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_b)
   );

   assign active      = (state_q != BOOT);
   assign lw_stall    = ResultSrcE0 && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign mem_timeout = (wait_q == WAIT_LAST);
   // A pending memory access freezes everything; ack or timeout releases it.
   assign mem_hold    = ((state_q == RUN) && MemAccessM && !MemAckM) ||
                        ((state_q == MEMWAIT) && !MemAckM && !mem_timeout);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= BOOT;
         boot_q      <= '0;
         wait_q      <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         boot_q      <= boot_d;
         wait_q      <= wait_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      boot_d      = boot_q;
      wait_d      = '0;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         BOOT: begin
            if (boot_q == BOOT_LAST) state_d = RUN;
            else                     boot_d  = boot_q + 1'b1;
         end
         RUN: begin
            if (MemAccessM && !MemAckM) state_d = MEMWAIT;
         end
         MEMWAIT: begin
            if (MemAckM) begin
               state_d = RUN;
            end else if (mem_timeout) begin
               state_d   = RUN;
               mem_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
      // Outside BOOT, FlushD is raised only by a taken branch.
      if (active && StallF && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (active && FlushD && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      MemReqM   = (state_q == MEMWAIT) || ((state_q == RUN) && MemAccessM);
      ForwardAE = active ? fwd_a : FWD_RF;
      ForwardBE = active ? fwd_b : FWD_RF;
      if (!active) begin
         StallF = 1'b1;
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (mem_hold) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   assign MemErr   = mem_err_q;
   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : vector table, corner sequences and random run vs. model
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;

   localparam int BOOT_CYCLES = 4;
   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_WIDTH   = 16;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, MemAckM;
   logic MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [1:0] ForwardAE, ForwardBE;
   logic [CNT_WIDTH-1:0] StallCnt, FlushCnt;
   logic [11:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .MemAckM(MemAckM),
      .MemReqM(MemReqM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReqM}
   assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReqM};

   localparam logic [11:0] P_BOOT = 12'b0000_1000_1100;
   localparam logic [11:0] P_HOLD = 12'b0000_1111_0011;

   typedef struct {
      string      name;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       ld, rwm, rww, pc, acc, ack;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input string n,
                               input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                               input logic ld, rwm, rww, pc, acc, ack,
                               input logic [11:0] exp);
      vec_t v;
      v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
      v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.ld = ld; v.rwm = rwm; v.rww = rww;
      v.pc = pc; v.acc = acc; v.ack = ack; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
      MemAccessM = 0; MemAckM = 0;
   endtask

   task automatic apply(input vec_t v);
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      ResultSrcE0 = v.ld; RegWriteM = v.rwm; RegWriteW = v.rww;
      PCSrcE = v.pc; MemAccessM = v.acc; MemAckM = v.ack;
   endtask

   task automatic reset_and_boot();
      idle();
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      repeat (BOOT_CYCLES) tick();
   endtask

   // ---------------- reference model (cycle-level pipeline rules) ----------------
   int m_boot_left, m_waited, m_sc, m_fc;
   bit m_wait, m_err;

   task automatic model_reset();
      m_boot_left = BOOT_CYCLES; m_waited = 0; m_sc = 0; m_fc = 0;
      m_wait = 0; m_err = 0;
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [11:0] model_outs();
      logic [11:0] e;
      bit frozen, lw;
      if (m_boot_left > 0) return P_BOOT;
      frozen = m_wait ? (!MemAckM && m_waited < MEM_TIMEOUT - 1) : (MemAccessM && !MemAckM);
      lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      e = {ref_fwd(Rs1E), ref_fwd(Rs2E), 8'b0};
      e[0] = m_wait || MemAccessM;
      if (frozen)      e[7:1] = 7'b1111_001;
      else if (PCSrcE) e[7:1] = 7'b0000_110;
      else if (lw)     e[7:1] = 7'b1100_010;
      return e;
   endfunction

   task automatic model_step(input logic [11:0] e);
      int cmax;
      cmax = (1 << CNT_WIDTH) - 1;
      if (m_boot_left > 0) begin
         m_boot_left--;
         return;
      end
      if (e[7] && m_sc < cmax) m_sc++;
      if (e[3] && m_fc < cmax) m_fc++;
      if (m_wait) begin
         if (MemAckM) begin
            m_wait = 0; m_waited = 0;
         end else if (m_waited == MEM_TIMEOUT - 1) begin
            m_wait = 0; m_waited = 0; m_err = 1;
         end else begin
            m_waited++;
         end
      end else if (MemAccessM && !MemAckM) begin
         m_wait = 1;
      end
   endtask

   initial begin
      logic [11:0] e;
      int ack_pct;

      vecs[0]  = mk("fwdA_M",     0, 0, 5, 0, 0, 5, 5,  0, 1, 1, 0, 0, 0, 12'b10_00_0000_000_0);
      vecs[1]  = mk("fwdA_W",     0, 0, 5, 0, 0, 5, 5,  0, 0, 1, 0, 0, 0, 12'b01_00_0000_000_0);
      vecs[2]  = mk("fwdA_zero",  0, 0, 0, 0, 0, 0, 5,  0, 1, 1, 0, 0, 0, 12'b00_00_0000_000_0);
      vecs[3]  = mk("fwdB_M",     0, 0, 0, 9, 0, 9, 9,  0, 1, 1, 0, 0, 0, 12'b00_10_0000_000_0);
      vecs[4]  = mk("fwdB_W",     0, 0, 0, 9, 0, 3, 9,  0, 1, 1, 0, 0, 0, 12'b00_01_0000_000_0);
      vecs[5]  = mk("lw_rs2",     0, 7, 0, 0, 7, 0, 0,  1, 0, 0, 0, 0, 0, 12'b00_00_1100_010_0);
      vecs[6]  = mk("lw_rd0",     0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 12'b00_00_0000_000_0);
      vecs[7]  = mk("lw_rs1",    12, 3, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 12'b00_00_1100_010_0);
      vecs[8]  = mk("branch",     0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 12'b00_00_0000_110_0);
      vecs[9]  = mk("branch_lw",  7, 0, 0, 0, 7, 0, 0,  1, 0, 0, 1, 0, 0, 12'b00_00_0000_110_0);
      vecs[10] = mk("mem_0wait",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 12'b00_00_0000_000_1);
      vecs[11] = mk("mem_0w_br",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 12'b00_00_0000_110_1);

      // Reset state, with busy inputs that must be ignored in BOOT
      apply(vecs[11]);
      RegWriteM = 1; RdM = 5; Rs1E = 5;
      rst = 1'b0;
      tick(); tick();
      #1;
      check("rst_outs", outs, P_BOOT);
      check("rst_err", MemErr, 0);
      check("rst_scnt", StallCnt, 0);
      check("rst_fcnt", FlushCnt, 0);

      // Boot flush lasts exactly BOOT_CYCLES cycles after release
      idle();
      tick();
      rst = 1'b1;
      for (int i = 0; i < BOOT_CYCLES + 2; i++) begin
         #1;
         check($sformatf("boot_%0d", i), outs, (i < BOOT_CYCLES) ? P_BOOT : 12'b0);
         tick();
      end
      check("boot_scnt", StallCnt, 0);

      // Vector table in RUN
      foreach (vecs[i]) begin
         apply(vecs[i]);
         #1;
         check(vecs[i].name, outs, vecs[i].exp);
         tick();
      end
      idle();
      check("tbl_scnt", StallCnt, 2);
      check("tbl_fcnt", FlushCnt, 3);

      // Delayed ack (3 stalled cycles) with a branch pending in Execute
      PCSrcE = 1; MemAccessM = 1;
      for (int c = 0; c < 4; c++) begin
         MemAckM = (c == 3);
         #1;
         check($sformatf("memwait_%0d", c), outs, (c < 3) ? P_HOLD : 12'b0000_0000_1101);
         tick();
      end
      idle();
      #1;
      check("memwait_after", outs, 12'b0);
      check("memwait_scnt", StallCnt, 5);
      check("memwait_fcnt", FlushCnt, 4);

      // Timeout: 16 stalled cycles, then release with sticky MemErr
      reset_and_boot();
      MemAccessM = 1;
      for (int c = 0; c < MEM_TIMEOUT; c++) begin
         #1;
         check($sformatf("tmo_hold_%0d", c), {MemErr, outs}, {1'b0, P_HOLD});
         tick();
      end
      #1;
      check("tmo_release", {MemErr, outs}, 13'b0_0000_0000_0001);
      tick();
      idle();
      #1;
      check("tmo_err", MemErr, 1);
      check("tmo_run", outs, 12'b0);
      check("tmo_scnt", StallCnt, MEM_TIMEOUT);
      repeat (5) tick();
      check("tmo_sticky", MemErr, 1);

      // Reset pulsed in the middle of a memory wait
      MemAccessM = 1;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("midrst_outs", outs, P_BOOT);
      check("midrst_err", MemErr, 0);
      check("midrst_scnt", StallCnt, 0);
      tick();

      // Random run against the reference model
      idle();
      model_reset();
      rst = 1'b1;
      ack_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) ack_pct = ($urandom_range(0, 1) != 0) ? 50 : 5;
         if (i > 0) rst = ($urandom_range(0, 399) != 0);
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         ResultSrcE0 = ($urandom_range(0, 99) < 40);
         RegWriteM   = ($urandom_range(0, 99) < 60);
         RegWriteW   = ($urandom_range(0, 99) < 60);
         PCSrcE      = ($urandom_range(0, 99) < 15);
         MemAccessM  = ($urandom_range(0, 99) < 40);
         MemAckM     = ($urandom_range(0, 99) < ack_pct);
         if (!rst) model_reset();
         #1;
         e = model_outs();
         check("rand_ctl", outs, e);
         check("rand_err", MemErr, m_err);
         check("rand_scnt", StallCnt, m_sc);
         check("rand_fcnt", FlushCnt, m_fc);
         if (rst) model_step(e);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RISC-V core, sitting beside the Fetch/Decode/Execute/Memory/Writeback stages.
- Generates forwarding selects, stall and flush enables for every pipeline register.
- Sequences the post-reset pipeline flush and the data-memory wait handshake.
- Keeps saturating stall and flush performance counters.

Parameters:
- BOOT_CYCLES, 4, cycles of forced pipeline flush after reset release (>=1)
- MEM_TIMEOUT, 16, max cycles waiting for MemAckM before declaring error (>=2)
- CNT_WIDTH, 16, width of performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E  in  5  source registers in Execute
- RdE, RdM, RdW  in  5  destination registers per stage
- ResultSrcE0  in  1  Execute holds a load (ResultSrcE[0])
- RegWriteM, RegWriteW  in  1  register write enables per stage
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MemAccessM  in  1  Memory stage holds a load or store
- MemAckM  in  1  data memory completes access this cycle
- MemReqM  out  1  request to data memory
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUResultM, 01 = ResultW
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  load a bubble into the corresponding register
- MemErr  out  1  sticky timeout flag
- StallCnt, FlushCnt  out  CNT_WIDTH  performance counters

Behaviour:
- Reset (rst=0, async): state=BOOT, boot counter=0, wait counter=0, MemErr=0, both counters=0.
- In reset, combinational outputs follow BOOT: StallF=1, FlushD=1, FlushE=1, MemReqM=0, ForwardAE/BE=00, all other stalls/flushes 0.
- State machine: BOOT, RUN, MEMWAIT.
- BOOT:
  - Outputs as in reset; boot counter increments each cycle.
  - After BOOT_CYCLES cycles, go to RUN. First fetch occurs in the first RUN cycle.
- Forwarding (combinational, RUN and MEMWAIT):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00. M has priority over W. ForwardBE is identical using Rs2E.
- Load-use (RUN): lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - lwStall gives StallF=StallD=1 and FlushE=1.
- Branch (RUN): PCSrcE gives FlushD=1 and FlushE=1.
  - Cannot coincide with lwStall, since E holds a single instruction. If both are seen, the branch wins: stalls 0, flushes 1.
- Memory handshake:
  - In RUN, MemReqM=MemAccessM.
  - If MemAccessM && MemAckM in the same cycle: zero-wait, no stall.
  - If MemAccessM && !MemAckM: next state MEMWAIT. That same cycle StallF/D/E/M=1 and FlushW=1; load-use and branch effects are suppressed.
- MEMWAIT:
  - MemReqM=1, StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0; wait counter increments.
  - On MemAckM: all stalls released that same cycle, and RUN rules (including pending PCSrcE/lwStall) apply in that cycle; next state RUN.
  - If wait counter reaches MEM_TIMEOUT-1 without ack: set MemErr (sticky until reset), release stalls, next state RUN.
  - Wait counter clears on leaving MEMWAIT.
- Counters:
  - StallCnt increments on every cycle with StallF=1 in RUN or MEMWAIT (not BOOT).
  - FlushCnt increments on every cycle with PCSrcE=1 whose flush takes effect.
  - Both saturate at all-ones.
- Reset asserted mid-MEMWAIT: immediate return to BOOT with all registers cleared.

Decomposition:
- Package hazard_pkg holds:
  - state enum (BOOT, RUN, MEMWAIT)
  - forwarding select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10)
  - REG_ZERO=5'd0
- One sub-module is natural: hazard_fwd, the purely combinational forwarding compare, instantiated once per operand (A and B).

Test Plan:
- Reset release, BOOT_CYCLES=4 -> StallF=FlushD=FlushE=1 for exactly 4 cycles after rst rises, then all 0 in RUN.
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Repeat with RegWriteM=0 -> 01. Repeat with Rs1E=0 and RdM=0 -> 00.
- ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCnt +1. With RdE=0 -> no stall.
- PCSrcE=1 in RUN -> FlushD=FlushE=1, no stalls, FlushCnt +1.
- MemAccessM=1 with ack delayed 3 cycles while PCSrcE=1 -> StallF/D/E/M=1 and FlushW=1 for 3 cycles with flushes suppressed. On the ack cycle: stalls 0, FlushD=FlushE=1, FlushCnt +1.
- MemAccessM=1 with no ack, MEM_TIMEOUT=16 -> MemErr=1 after 16 stalled cycles, state RUN, MemErr stays 1 until rst=0. rst pulsed low mid-wait -> all outputs at BOOT values immediately.
